// File: rtl/seg_scan_if.sv
// Bus between the datapath and the seven-segment scan driver: display
// configuration in, multiplexed anode/segment pins out.
interface seg_scan_if #(
    parameter int unsigned DIGITS = 8
);
    logic [4*DIGITS-1:0] data;
    logic [DIGITS-1:0]   dig_en;
    logic [DIGITS-1:0]   dp;
    logic [DIGITS-1:0]   blink;
    logic                lz_blank;
    logic [3:0]          bright;
    logic                load;
    logic [DIGITS-1:0]   an;
    logic [6:0]          seg;
    logic                dp_n;
    logic                frame_tick;

    modport master (
        output data, dig_en, dp, blink, lz_blank, bright, load,
        input  an, seg, dp_n, frame_tick
    );

    modport slave (
        input  data, dig_en, dp, blink, lz_blank, bright, load,
        output an, seg, dp_n, frame_tick
    );
endinterface

// File: rtl/seg_scan_mux_n.sv
// Multi-digit seven-segment scan driver: double-buffered config, per-digit
// enable/dp/blink, leading-zero blanking and 16-level PWM brightness.
module seg_scan_mux_n #(
    parameter int unsigned DIGITS       = 8,
    parameter int unsigned SCAN_DIV     = 200000,
    parameter int unsigned BLINK_FRAMES = 32
) (
    input  logic        clkd,
    input  logic        rstn,
    seg_scan_if.slave   bus
);
    localparam int unsigned CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int unsigned FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam int unsigned SW = SCAN_DIV / 16;

    typedef struct packed {
        logic [4*DIGITS-1:0] data;
        logic [DIGITS-1:0]   dig_en;
        logic [DIGITS-1:0]   dp;
        logic [DIGITS-1:0]   blink;
        logic                lz_blank;
        logic [3:0]          bright;
    } cfg_t;

    localparam cfg_t CFG_RST = '{data: '0, dig_en: '0, dp: '0, blink: '0,
                                 lz_blank: 1'b0, bright: 4'hF};

    function automatic logic [6:0] hex_decode(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'h01;  4'h1: s = 7'h4F;  4'h2: s = 7'h12;  4'h3: s = 7'h06;
            4'h4: s = 7'h4C;  4'h5: s = 7'h24;  4'h6: s = 7'h20;  4'h7: s = 7'h0F;
            4'h8: s = 7'h00;  4'h9: s = 7'h04;  4'hA: s = 7'h08;  4'hB: s = 7'h60;
            4'hC: s = 7'h31;  4'hD: s = 7'h42;  4'hE: s = 7'h30;  default: s = 7'h38;
        endcase
        return s;
    endfunction

    cfg_t              act_q, act_d, pend_q, pend_d, in_c;
    logic              pend_v_q, pend_v_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [FW-1:0]     fc_q, fc_d;
    logic              phase_q, phase_d;
    logic [DIGITS-1:0] an_q, an_d;
    logic [6:0]        seg_q, seg_d;
    logic              dp_n_q, dp_n_d;
    logic              ft_q, ft_d;

    logic              slot_end_c, wrap_c, lit_c;
    logic [3:0]        nib_c;
    logic [31:0]       thr_c;
    logic [DIGITS-1:0] lz_c;
    logic              zero_run_c;

    assign in_c = '{data: bus.data, dig_en: bus.dig_en, dp: bus.dp, blink: bus.blink,
                    lz_blank: bus.lz_blank, bright: bus.bright};

    // Scan timing, blink phase and config double buffer
    always_comb begin
        slot_end_c = (cnt_q == CW'(SCAN_DIV - 1));
        wrap_c     = slot_end_c && (idx_q == IW'(DIGITS - 1));
        cnt_d      = slot_end_c ? '0 : cnt_q + CW'(1);
        idx_d      = idx_q;
        fc_d       = fc_q;
        phase_d    = phase_q;
        if (slot_end_c) begin
            idx_d = wrap_c ? '0 : idx_q + IW'(1);
        end
        if (wrap_c) begin
            if (fc_q == FW'(BLINK_FRAMES - 1)) begin
                fc_d    = '0;
                phase_d = ~phase_q;
            end else begin
                fc_d = fc_q + FW'(1);
            end
        end
        // A load on the wrap cycle stays pending for the following wrap
        pend_d   = bus.load ? in_c : pend_q;
        pend_v_d = bus.load | (pend_v_q & ~wrap_c);
        act_d    = (wrap_c && pend_v_q) ? pend_q : act_q;
    end

    // Leading-zero run from the top, skipping disabled digits
    always_comb begin
        lz_c       = '0;
        zero_run_c = act_q.lz_blank;
        for (int i = int'(DIGITS) - 1; i >= 1; i--) begin
            lz_c[i] = zero_run_c && (act_q.data[4*i +: 4] == 4'h0);
            if (act_q.dig_en[i]) begin
                zero_run_c = zero_run_c && (act_q.data[4*i +: 4] == 4'h0);
            end
        end
    end

    // Pin drive for the current slot, registered below
    always_comb begin
        an_d   = '1;
        seg_d  = 7'h7F;
        dp_n_d = 1'b1;
        ft_d   = wrap_c;
        nib_c  = act_q.data[4*idx_q +: 4];
        thr_c  = (32'(act_q.bright) + 32'd1) * 32'(SW);
        lit_c  = act_q.dig_en[idx_q] && !(act_q.blink[idx_q] && phase_q)
                 && (32'(cnt_q) < thr_c);
        if (lit_c) begin
            an_d   = ~(DIGITS'(1) << idx_q);
            seg_d  = lz_c[idx_q] ? 7'h7F : hex_decode(nib_c);
            dp_n_d = ~act_q.dp[idx_q];
        end
    end

    always_ff @(posedge clkd or negedge rstn) begin
        if (!rstn) begin
            act_q    <= CFG_RST;
            pend_q   <= CFG_RST;
            pend_v_q <= 1'b0;
            cnt_q    <= '0;
            idx_q    <= '0;
            fc_q     <= '0;
            phase_q  <= 1'b0;
            an_q     <= '1;
            seg_q    <= 7'h7F;
            dp_n_q   <= 1'b1;
            ft_q     <= 1'b0;
        end else begin
            act_q    <= act_d;
            pend_q   <= pend_d;
            pend_v_q <= pend_v_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            fc_q     <= fc_d;
            phase_q  <= phase_d;
            an_q     <= an_d;
            seg_q    <= seg_d;
            dp_n_q   <= dp_n_d;
            ft_q     <= ft_d;
        end
    end

    assign bus.an         = an_q;
    assign bus.seg        = seg_q;
    assign bus.dp_n       = dp_n_q;
    assign bus.frame_tick = ft_q;
endmodule

// File: doc/seg_scan_mux_n.md
Name: seg_scan_mux_n

Overview:
Parametrised multi-digit seven-segment scan driver for the board display, successor to the fixed 4-digit scanner. It time-multiplexes DIGITS hex digits onto shared active-low segment/anode lines, with:
- a double-buffered input so updates never tear mid-frame;
- per-digit enable, decimal point and blink control;
- leading-zero blanking;
- 16-level PWM brightness.

It sits between datapath registers and the board anode/segment pins.

Parameters:
DIGITS, 8, number of digits scanned (2..8)
SCAN_DIV, 200000, clkd cycles per digit slot; must be a multiple of 16, minimum 16
BLINK_FRAMES, 32, frames per blink half-period (minimum 1)

Ports:
clkd  in  1  clock
rstn  in  1  asynchronous active-low reset
data  in  4*DIGITS  hex nibbles; digit i = data[4i+3:4i], digit 0 rightmost
dig_en  in  DIGITS  1 = digit i enabled
dp  in  DIGITS  1 = decimal point i lit
blink  in  DIGITS  1 = digit i blinks
lz_blank  in  1  enable leading-zero blanking
bright  in  4  brightness 0 (dimmest) .. 15 (full)
load  in  1  single-cycle strobe: capture all inputs above
an  out  DIGITS  anode selects, active low
seg  out  7  segments a..g on seg[6]..seg[0], active low
dp_n  out  1  decimal point, active low
frame_tick  out  1  one-cycle pulse at each frame wrap

Behaviour:
- Interface: reset rstn, asynchronous, active-low; clock clkd. All state is clocked on posedge clkd and cleared on negedge rstn.

Double buffering:
- load=1 copies data, dig_en, dp, blink, lz_blank and bright into the pending register and sets pend_v.
- On the frame wrap cycle, if pend_v, pending is copied to the active register and pend_v is cleared.
- load on the same cycle as a wrap: the wrap commits the old pending contents; the new values go to pending and commit at the next wrap.
- Consecutive loads before a wrap: the last load wins.
- Reset values: active and pending data/dp/blink/lz_blank = 0, dig_en = 0 (display dark), bright = 15, pend_v = 0.

Scan:
- cnt counts 0..SCAN_DIV-1. slot_end = (cnt == SCAN_DIV-1).
- idx advances at slot_end and wraps DIGITS-1 -> 0.
- The wrap cycle is slot_end with idx == DIGITS-1. frame_tick is registered and is high the cycle after the wrap.
- Reset: cnt=0, idx=0.

Brightness:
- The digit is driven while cnt < (bright+1)*(SCAN_DIV/16); otherwise an is all ones, seg=7'h7F and dp_n=1.
- bright=15 drives the whole slot.

Blink:
- frame counter fc counts 0..BLINK_FRAMES-1 on each wrap. phase toggles when fc wraps. Reset: fc=0, phase=0.
- When phase=1, digits with blink=1 are dark.

Leading-zero blanking:
- When lz_blank=1, digit i (i ≥ 1) is LZ-blank if digit i and every enabled higher digit has nibble 0.
- Disabled digits are ignored in this test.
- Digit 0 is never LZ-blanked.
- An LZ-blank digit keeps its anode asserted with seg=7'h7F, but dp_n still follows dp.

Per slot output:
- Disabled digit or blink-dark digit: an all ones.
- Otherwise an = ~(1<<idx), seg = decode(nibble), dp_n = ~dp[idx].
- Decode table (hex): 0:01 1:4F 2:12 3:06 4:4C 5:24 6:20 7:0F 8:00 9:04 A:08 b:60 C:31 d:42 E:30 F:38.

Output timing and reset:
- an, seg and dp_n are registered: one-cycle latency from cnt/idx.
- Exactly one anode is low at a time; all anodes are high when the digit is dark.
- Reset values: an all ones, seg=7'h7F, dp_n=1, frame_tick=0.
- rstn asserted mid-frame returns to digit 0, dark, with pending discarded.

Test Plan:
Bench uses DIGITS=4, SCAN_DIV=16, BLINK_FRAMES=2.
- Reset, then load data=16'h12AF, dig_en=4'hF, bright=15 -> after the first wrap, slots show an=1110/1101/1011/0111 with seg=38/08/12/4F for 16 cycles each; frame_tick pulses every 64 cycles.
- Load data=16'h0030, lz_blank=1 -> digit 3 and digit 2 have an low with seg=7F; digit 1 shows 06; digit 0 shows 01. dp[3]=1 -> dp_n=0 during digit 3's slot.
- bright=3 -> an low for cnt 0..3 of each slot and high for cnt 4..15. bright=0 -> 1 cycle per slot.
- Mid-frame: load 16'hFFFF while displaying 16'h1111 -> the remaining slots of the current frame still show 4F; the next frame shows 38. Also check load coinciding with the wrap cycle, which defers to the following wrap.
- blink=4'b0001 -> digit 0 is lit for 2 frames, dark for 2 frames, repeating; the other digits are unaffected.
- Assert rstn low mid-slot -> an=all ones, seg=7F, dp_n=1, frame_tick=0 immediately without a clock edge. After release, the display stays dark until a load followed by a wrap.
